mine_count_selector: RTL and testbench

MINE_COUNT_SELECTOR -- requirements
Module: mine_count_selector

---
 rtl/mine_count_selector.sv | 123 ++++++++++++
 tb/tb_mine_count_selector.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mine_count_selector.sv
// mine_count_selector
//   Turns a bank of thermometer-coded switches into a mine count. The
//   switches are synchronized and debounced, and the stable pattern is
//   decoded. The resulting count can be locked for the length of a game.
//
// state  | meaning
// SELECT | mine_count previews the debounced switch pattern
// LOCKED | mine_count frozen; only release_req leaves
//
// Ports
//   clk          rising-edge clock for all state
//   rst          asynchronous active-low reset
//   sw           raw switch levels, bit 0 = first switch
//   confirm      single-cycle request to lock the selection
//   release_req  single-cycle request to unlock. This is the "release" input;
//                it is renamed because release is a reserved word.
//   mine_count   selected mine count (registered)
//   locked       high while LOCKED (registered)
//   sel_error    debounced pattern is not a thermometer code (registered)
//   reject       one-cycle pulse after a refused confirm (registered)
module mine_count_selector #(
  parameter int N_SW      = 6,
  parameter int MAX_MINES = 63,
  parameter int DB_CYCLES = 4,
  localparam int W        = $clog2(MAX_MINES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw,
  input  logic            confirm,
  input  logic            release_req,
  output logic [W-1:0]    mine_count,
  output logic            locked,
  output logic            sel_error,
  output logic            reject
);

  typedef enum logic {SELECT = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state;
  logic [N_SW-1:0] sync1, sync2, cand, db;
  logic [7:0]      cnt, cnt_next;
  logic            dec_valid;
  logic [W-1:0]    dec_count;

  // Down-counter of remaining stable cycles. A change in the synchronized
  // value reloads the counter. The counter reaching zero commits the pattern
  // on the same edge. As a result DB_CYCLES=1 commits on the first edge
  // that sees the new value.
  always_comb begin
    cnt_next = 8'd0;
    if (sync2 != cand)
      cnt_next = 8'(DB_CYCLES - 1);
    else if (cnt != 8'd0)
      cnt_next = cnt - 8'd1;
  end

  // Thermometer decode: a valid pattern plus one is a power of two.
  always_comb begin
    logic [N_SW:0] ext;
    int            k;
    int            val;
    ext = {1'b0, db};
    dec_valid = ((ext + 1'b1) & ext) == '0;
    k = 0;
    for (int i = 0; i < N_SW; i++)
      k += int'(db[i]);
    if (k == 0)
      val = 0;
    else if (k >= N_SW)
      val = MAX_MINES;
    else
      val = ((1 << k) > MAX_MINES) ? MAX_MINES : (1 << k);
    dec_count = W'(val);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SELECT;
      sync1      <= '0;
      sync2      <= '0;
      cand       <= '0;
      cnt        <= 8'd0;
      db         <= '0;
      mine_count <= '0;
      locked     <= 1'b0;
      sel_error  <= 1'b0;
      reject     <= 1'b0;
    end else begin
      sync1  <= sw;
      sync2  <= sync1;
      cand   <= sync2;
      cnt    <= cnt_next;
      if (cnt_next == 8'd0)
        db <= sync2;
      reject <= 1'b0;
      case (state)
        SELECT: begin
          if (confirm && !sel_error && mine_count != '0) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end else begin
            reject <= confirm;
            if (dec_valid)
              mine_count <= dec_count;
            sel_error <= !dec_valid;
          end
        end
        LOCKED: begin
          if (release_req) begin
            state  <= SELECT;
            locked <= 1'b0;
            if (dec_valid)
              mine_count <= dec_count;
            sel_error <= !dec_valid;
          end
        end
        default: state <= SELECT;
      endcase
    end
  end

endmodule

// File: tb/tb_mine_count_selector.sv
module tb_mine_count_selector;

  localparam int N_SW = 6;
  localparam int W    = 6;

  typedef struct {
    logic [N_SW-1:0] sw;
    int              cnt;
    logic            err;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N_SW-1:0] sw = '0;
  logic            confirm = 1'b0;
  logic            rel = 1'b0;
  logic [W-1:0]    mine_count;
  logic            locked, sel_error, reject;

  int   total = 0;
  int   bad = 0;
  vec_t vecs[10];
  vec_t exp_q[$];
  vec_t prev;

  mine_count_selector #(.N_SW(6), .MAX_MINES(63), .DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .sw(sw), .confirm(confirm), .release_req(rel),
    .mine_count(mine_count), .locked(locked), .sel_error(sel_error),
    .reject(reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic c, input logic r);
    confirm = c;
    rel = r;
    tick();
    confirm = 1'b0;
    rel = 1'b0;
  endtask

  // Drive a pattern, then verify that outputs are unchanged after 6 edges
  // and show the expected result after exactly 7 edges.
  task automatic apply(input vec_t v, input string name);
    vec_t e;
    sw = v.sw;
    exp_q.push_back(v);
    repeat (6) tick();
    chk({name, "_early_cnt"}, int'(mine_count), prev.cnt);
    chk({name, "_early_err"}, int'(sel_error), int'(prev.err));
    tick();
    e = exp_q.pop_front();
    chk({name, "_cnt"}, int'(mine_count), e.cnt);
    chk({name, "_err"}, int'(sel_error), int'(e.err));
    if (!e.err) prev.cnt = e.cnt;
    prev.err = e.err;
    prev.sw = e.sw;
  endtask

  initial begin
    vecs[0] = '{6'b000011,  4, 1'b0};
    vecs[1] = '{6'b111111, 63, 1'b0};
    vecs[2] = '{6'b011111, 32, 1'b0};
    vecs[3] = '{6'b000001,  2, 1'b0};
    vecs[4] = '{6'b000000,  0, 1'b0};
    vecs[5] = '{6'b000111,  8, 1'b0};
    vecs[6] = '{6'b000101,  8, 1'b1};
    vecs[7] = '{6'b001111, 16, 1'b0};
    vecs[8] = '{6'b110000, 16, 1'b1};
    vecs[9] = '{6'b000011,  4, 1'b0};
    prev = '{6'b000000, 0, 1'b0};

    #2;
    chk("rst_cnt", int'(mine_count), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(sel_error), 0);
    chk("rst_reject", int'(reject), 0);
    tick();
    rst = 1'b1;

    for (int i = 0; i < 10; i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Non-thermometer pattern holds the count; confirm is refused.
    apply('{6'b000101, 4, 1'b1}, "bad_pat");
    pulse(1'b1, 1'b0);
    chk("rej_pulse", int'(reject), 1);
    chk("rej_locked", int'(locked), 0);
    tick();
    chk("rej_one_cycle", int'(reject), 0);

    // A glitch shorter than the debounce window is filtered out.
    apply('{6'b000011, 4, 1'b0}, "glitch_base");
    sw = 6'b000111;
    repeat (3) tick();
    sw = 6'b000011;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("glitch_cnt", int'(mine_count), 4);
      chk("glitch_err", int'(sel_error), 0);
    end

    // A zero count cannot be locked.
    apply('{6'b000000, 0, 1'b0}, "zero");
    pulse(1'b1, 1'b0);
    chk("zero_reject", int'(reject), 1);
    chk("zero_locked", int'(locked), 0);

    // Lock at 8 and check that the frozen count ignores the switches.
    apply('{6'b000111, 8, 1'b0}, "lock8");
    pulse(1'b1, 1'b0);
    chk("lock_locked", int'(locked), 1);
    chk("lock_cnt", int'(mine_count), 8);
    chk("lock_reject", int'(reject), 0);
    sw = 6'b111111;
    repeat (20) tick();
    chk("frozen_cnt", int'(mine_count), 8);
    chk("frozen_err", int'(sel_error), 0);
    pulse(1'b1, 1'b0);
    chk("locked_confirm_ignored", int'(locked), 1);
    chk("locked_confirm_noreject", int'(reject), 0);
    pulse(1'b0, 1'b1);
    chk("unlock_locked", int'(locked), 0);
    chk("unlock_cnt", int'(mine_count), 63);

    // Simultaneous confirm and release, and release while in SELECT.
    pulse(1'b0, 1'b1);
    chk("sel_release_ignored", int'(locked), 0);
    chk("sel_release_noreject", int'(reject), 0);
    pulse(1'b1, 1'b1);
    chk("both_in_select", int'(locked), 1);
    pulse(1'b1, 1'b1);
    chk("both_in_locked", int'(locked), 0);

    // An asynchronous reset while LOCKED discards the frozen value.
    prev = '{6'b111111, 63, 1'b0};
    apply('{6'b001111, 16, 1'b0}, "pre_rst");
    pulse(1'b1, 1'b0);
    chk("pre_rst_locked", int'(locked), 1);
    #3 rst = 1'b0;
    #1;
    chk("arst_cnt", int'(mine_count), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_err", int'(sel_error), 0);
    chk("arst_reject", int'(reject), 0);
    #2;
    sw = 6'b000001;
    rst = 1'b1;
    repeat (6) tick();
    chk("post_rst_early", int'(mine_count), 0);
    tick();
    chk("post_rst_cnt", int'(mine_count), 2);
    chk("post_rst_locked", int'(locked), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
